oscillator_voice: RTL and testbench

Parametrised single-voice oscillator. It owns the phase accumulator, a noise LFSR and a registered waveform mux. Triangle, sawtooth, pulse and noise are combinable by bitwise AND, with hard sync, ring modulation and a test/hold bit. Voices chain: msb_rise of voice N feeds sync_in of voice N+1; acc_msb of voice N feeds ringmod_source of voice N+1. The block sits between the register file and the envelope/DAC stage.

---
 rtl/oscillator_voice_if.sv | 30 +++
 rtl/oscillator_voice.sv | 81 ++++++++
 tb/tb_oscillator_voice.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oscillator_voice_if.sv
// Register-file side bus for one oscillator voice: tick, controls, chain strobes and sample.
// The voice drives out/acc_msb/msb_rise; everything else comes from the register file or the previous voice.
// No handshake: clk_en is the sample tick and the voice consumes controls on every tick.
interface oscillator_voice_if #(
  parameter int FREQ_BITS   = 16,
  parameter int OUTPUT_BITS = 12
);
  logic                   clk_en;
  logic [FREQ_BITS-1:0]   freq;
  logic [OUTPUT_BITS-1:0] pw;
  logic [3:0]             wave_sel;
  logic                   test;
  logic                   en_sync;
  logic                   sync_in;
  logic                   en_ringmod;
  logic                   ringmod_source;
  logic [OUTPUT_BITS-1:0] out;
  logic                   acc_msb;
  logic                   msb_rise;

  modport master (
    output clk_en, freq, pw, wave_sel, test, en_sync, sync_in, en_ringmod, ringmod_source,
    input  out, acc_msb, msb_rise
  );

  modport slave (
    input  clk_en, freq, pw, wave_sel, test, en_sync, sync_in, en_ringmod, ringmod_source,
    output out, acc_msb, msb_rise
  );
endinterface

// File: rtl/oscillator_voice.sv
// Single oscillator voice: phase accumulator, noise LFSR and registered waveform mux.
// Latency: out lags acc/lfsr by one clk; msb_rise is combinational within the tick.
// Backpressure: none; state advances only on clk_en ticks, out reloads every clk.
module oscillator_voice #(
  parameter int ACCUMULATOR_BITS = 24,
  parameter int OUTPUT_BITS      = 12,
  parameter int FREQ_BITS        = 16,
  parameter int NOISE_BITS       = 23,
  parameter int NOISE_CLK_BIT    = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  oscillator_voice_if.slave  bus
);
  localparam int MSB = ACCUMULATOR_BITS - 1;

  logic [ACCUMULATOR_BITS-1:0] acc_q, acc_d, acc_next;
  logic [NOISE_BITS-1:0]       lfsr_q, lfsr_d;
  logic [OUTPUT_BITS-1:0]      out_q, out_d;
  logic [OUTPUT_BITS-1:0]      saw_w, tri_w, pulse_w, noise_w;
  logic                        invert;
  logic                        noise_clk;

  // Phase selection: test beats hard sync beats the free-running add (wrap is silent).
  always_comb begin
    acc_next = acc_q + ACCUMULATOR_BITS'(bus.freq);
    if (bus.test) begin
      acc_next = '0;
    end else if (bus.en_sync && bus.sync_in) begin
      acc_next = '0;
    end
    acc_d = bus.clk_en ? acc_next : acc_q;
  end

  // Rising edges are judged against the candidate phase, so clears never look like rises.
  assign bus.msb_rise = bus.clk_en & ~acc_q[MSB] & acc_next[MSB];
  assign noise_clk    = ~acc_q[NOISE_CLK_BIT] & acc_next[NOISE_CLK_BIT];

  // Noise LFSR: reseeded by test, stepped by a rising accumulator tap bit.
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.clk_en) begin
      if (bus.test) begin
        lfsr_d = '1;
      end else if (noise_clk) begin
        lfsr_d = {lfsr_q[NOISE_BITS-2:0], lfsr_q[NOISE_BITS-1] ^ lfsr_q[NOISE_BITS-6]};
      end
    end
  end

  // Waveform terms from the current phase, combined by bitwise AND of the selected ones.
  always_comb begin
    saw_w   = acc_q[MSB -: OUTPUT_BITS];
    invert  = bus.en_ringmod ? (acc_q[MSB] ^ bus.ringmod_source) : acc_q[MSB];
    tri_w   = invert ? ~acc_q[MSB-1 -: OUTPUT_BITS] : acc_q[MSB-1 -: OUTPUT_BITS];
    pulse_w = (bus.test || (saw_w >= bus.pw)) ? '1 : '0;
    noise_w = lfsr_q[NOISE_BITS-1 -: OUTPUT_BITS];
    out_d   = '1;
    if (bus.wave_sel[0]) out_d = out_d & tri_w;
    if (bus.wave_sel[1]) out_d = out_d & saw_w;
    if (bus.wave_sel[2]) out_d = out_d & pulse_w;
    if (bus.wave_sel[3]) out_d = out_d & noise_w;
    if (bus.wave_sel == 4'b0000) out_d = '0;
  end

  // State registers; the sample register reloads every clk regardless of the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      lfsr_q <= '1;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.acc_msb = acc_q[MSB];
endmodule

// File: tb/tb_oscillator_voice.sv
// Two chained voices (master -> slave) checked against an arithmetic reference model.
// Expected outputs are queued per cycle and compared by a separate negedge monitor.
// Directed points from the feature list are checked against fixed constants as well.
module tb_oscillator_voice;
  localparam int unsigned ACC_MASK  = 32'h00FF_FFFF;
  localparam int unsigned HALF      = 32'h0080_0000;
  localparam int unsigned LFSR_ONES = 32'h007F_FFFF;

  typedef struct {
    int          voice;
    int unsigned out;
    bit          msb;
    bit          rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  oscillator_voice_if m_if ();
  oscillator_voice_if s_if ();

  assign s_if.sync_in        = m_if.msb_rise;
  assign s_if.ringmod_source = m_if.acc_msb;

  oscillator_voice dut_m (.clk(clk), .rst_n(rst_n), .bus(m_if));
  oscillator_voice dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if));

  // stimulus state
  bit          s_clk_en;
  int unsigned s_freq [2];
  int unsigned s_pw   [2];
  bit [3:0]    s_ws   [2];
  bit          s_test [2];
  bit          s_en_sync [2];
  bit          s_en_ring [2];
  bit          s_sync_in;
  bit          s_ring_src;

  // reference model state
  int unsigned m_acc  [2];
  int unsigned m_lfsr [2];
  int unsigned m_out  [2];

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit top(input int unsigned acc);
    return acc >= HALF;
  endfunction

  function automatic int unsigned next_acc(input int unsigned acc, input int unsigned freq,
                                           input bit tst, input bit sync);
    if (tst || sync) return 0;
    return (acc + freq) & ACC_MASK;
  endfunction

  function automatic int unsigned wave(input int unsigned acc, input int unsigned lfsr,
                                       input bit [3:0] ws, input int unsigned pw,
                                       input bit tst, input bit enr, input bit rsrc);
    int unsigned saw, ramp, tri_v, res;
    bit flip;
    saw   = acc / 4096;
    ramp  = (acc / 2048) % 4096;
    flip  = enr ? (top(acc) != rsrc) : top(acc);
    tri_v = flip ? (4095 - ramp) : ramp;
    res   = 4095;
    if (ws == 4'b0000) return 0;
    if (ws[0]) res = res & tri_v;
    if (ws[1]) res = res & saw;
    if (ws[2]) res = res & ((tst || saw >= pw) ? 4095 : 0);
    if (ws[3]) res = res & (lfsr / 2048);
    return res;
  endfunction

  function automatic int unsigned lfsr_step(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 22) ^ (l >> 17)) & 1;
    return ((l << 1) | fb) & LFSR_ONES;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_acc[v]  = 0;
      m_lfsr[v] = LFSR_ONES;
      m_out[v]  = 0;
    end
  endtask

  // Push this cycle's expectations, then advance the model across the coming edge.
  task automatic model_cycle();
    int unsigned nxt [2];
    bit          rise [2];
    bit          sync_v, ring_v;
    exp_t        e;
    for (int v = 0; v < 2; v++) begin
      sync_v  = (v == 0) ? s_sync_in  : rise[0];
      ring_v  = (v == 0) ? s_ring_src : top(m_acc[0]);
      nxt[v]  = next_acc(m_acc[v], s_freq[v], s_test[v], s_en_sync[v] && sync_v);
      rise[v] = s_clk_en && !top(m_acc[v]) && top(nxt[v]);
      e.voice = v;
      e.out   = m_out[v];
      e.msb   = top(m_acc[v]);
      e.rise  = rise[v];
      exp_q.push_back(e);
      m_out[v] = wave(m_acc[v], m_lfsr[v], s_ws[v], s_pw[v], s_test[v], s_en_ring[v], ring_v);
    end
    if (s_clk_en) begin
      for (int v = 0; v < 2; v++) begin
        if (s_test[v]) m_lfsr[v] = LFSR_ONES;
        else if (((m_acc[v] >> 19) & 1) == 0 && ((nxt[v] >> 19) & 1) == 1)
          m_lfsr[v] = lfsr_step(m_lfsr[v]);
        m_acc[v] = nxt[v];
      end
    end
  endtask

  task automatic drive();
    m_if.clk_en         = s_clk_en;
    m_if.freq           = 16'(s_freq[0]);
    m_if.pw             = 12'(s_pw[0]);
    m_if.wave_sel       = s_ws[0];
    m_if.test           = s_test[0];
    m_if.en_sync        = s_en_sync[0];
    m_if.sync_in        = s_sync_in;
    m_if.en_ringmod     = s_en_ring[0];
    m_if.ringmod_source = s_ring_src;
    s_if.clk_en         = s_clk_en;
    s_if.freq           = 16'(s_freq[1]);
    s_if.pw             = 12'(s_pw[1]);
    s_if.wave_sel       = s_ws[1];
    s_if.test           = s_test[1];
    s_if.en_sync        = s_en_sync[1];
    s_if.en_ringmod     = s_en_ring[1];
  endtask

  // One clk: optional mid-cycle reset pulse, apply inputs, model, then the edge.
  task automatic cycle(input bit do_rst);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check("rst_out_m",  m_if.out, 0);
      check("rst_out_s",  s_if.out, 0);
      check("rst_msb_m",  m_if.acc_msb, 0);
      check("rst_acc_m",  dut_m.acc_q, 0);
      check("rst_lfsr_m", dut_m.lfsr_q, LFSR_ONES);
      model_reset();
      rst_n = 1'b1;
    end
    drive();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic settle();
    s_clk_en = 1'b0;
    cycle(1'b0);
    s_clk_en = 1'b1;
  endtask

  task automatic clear_phase();
    s_test[0] = 1'b1;
    s_test[1] = 1'b1;
    cycle(1'b0);
    s_test[0] = 1'b0;
    s_test[1] = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the live outputs at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.voice == 0) begin
          check("m_out",  m_if.out,      e.out);
          check("m_msb",  m_if.acc_msb,  32'(e.msb));
          check("m_rise", m_if.msb_rise, 32'(e.rise));
        end else begin
          check("s_out",  s_if.out,      e.out);
          check("s_msb",  s_if.acc_msb,  32'(e.msb));
          check("s_rise", s_if.msb_rise, 32'(e.rise));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_clk_en = 1'b1;
    s_sync_in = 1'b0;
    s_ring_src = 1'b0;
    for (int v = 0; v < 2; v++) begin
      s_freq[v] = 0; s_pw[v] = 0; s_ws[v] = 4'b0010;
      s_test[v] = 1'b0; s_en_sync[v] = 1'b0; s_en_ring[v] = 1'b0;
    end
    model_reset();
    drive();
    @(posedge clk);
    #1;
    cycle(1'b1);

    // reset mid-run, then first tick from zero
    s_freq[0] = 32'h1234;
    run(256);
    s_freq[0] = 32'h1000;
    cycle(1'b1);
    check("post_rst_acc", dut_m.acc_q, 32'h001000);
    settle();
    check("post_rst_out", m_if.out, 32'h001);

    // sawtooth, rise and wrap
    clear_phase();
    run(16);
    check("saw_acc16", dut_m.acc_q, 32'h010000);
    settle();
    check("saw_out16", m_if.out, 32'h010);
    clear_phase();
    run(32'h7FF);
    check("rise_before", m_if.msb_rise, 1);
    check("msb_low", m_if.acc_msb, 0);
    run(1);
    check("msb_high", m_if.acc_msb, 1);
    check("no_rise_mid", m_if.msb_rise, 0);
    run(32'h7FF);
    check("no_rise_wrap", m_if.msb_rise, 0);
    run(1);
    check("wrap_acc", dut_m.acc_q, 0);

    // triangle and ring modulation
    s_ws[0] = 4'b0001;
    s_freq[0] = 32'h8000;
    clear_phase();
    run(128);
    settle();
    check("tri_40", m_if.out, 32'h800);
    run(256);
    settle();
    check("tri_C0", m_if.out, 32'h7FF);
    s_en_ring[0] = 1'b1;
    s_ring_src = 1'b1;
    settle();
    check("ring_C0", m_if.out, 32'h800);
    clear_phase();
    run(128);
    settle();
    check("ring_40", m_if.out, 32'h7FF);
    s_en_ring[0] = 1'b0;
    s_ring_src = 1'b0;

    // pulse and test hold
    s_ws[0] = 4'b0100;
    s_pw[0] = 32'h800;
    s_freq[0] = 32'h1000;
    clear_phase();
    run(32'h7FF);
    settle();
    check("pulse_7FF", m_if.out, 32'h000);
    run(1);
    settle();
    check("pulse_800", m_if.out, 32'hFFF);
    s_test[0] = 1'b1;
    run(1);
    check("test_acc", dut_m.acc_q, 0);
    check("test_lfsr", dut_m.lfsr_q, LFSR_ONES);
    run(3);
    settle();
    check("test_pulse", m_if.out, 32'hFFF);
    s_test[0] = 1'b0;
    s_ws[0] = 4'b0110;
    run(32'h900);
    settle();
    check("saw_and_pulse", m_if.out, 32'h900);

    // sync chain
    s_freq[0] = 32'h8000;
    s_freq[1] = 32'h0100;
    s_ws[1] = 4'b0010;
    s_en_sync[1] = 1'b1;
    clear_phase();
    run(255);
    check("chain_rise", m_if.msb_rise, 1);
    run(1);
    check("chain_synced", dut_s.acc_q, 0);
    s_en_sync[1] = 1'b0;
    clear_phase();
    run(256);
    check("chain_nosync", dut_s.acc_q, 32'h010000);
    clear_phase();
    s_test[1] = 1'b1;
    run(256);
    check("chain_test", dut_s.acc_q, 0);
    s_test[1] = 1'b0;

    // noise stepping
    s_ws[0] = 4'b1000;
    clear_phase();
    run(16);
    check("noise_t16", dut_m.lfsr_q, 32'h7FFFFE);
    run(31);
    check("noise_t47", dut_m.lfsr_q, 32'h7FFFFE);
    run(1);
    check("noise_t48", dut_m.lfsr_q, 32'h7FFFFC);
    clear_phase();
    s_en_sync[0] = 1'b1;
    run(31);
    check("sync_pre_acc", dut_m.acc_q, 32'h0F8000);
    s_sync_in = 1'b1;
    run(1);
    check("sync_clr_acc", dut_m.acc_q, 0);
    check("sync_no_step", dut_m.lfsr_q, 32'h7FFFFE);
    s_sync_in = 1'b0;
    s_en_sync[0] = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s_clk_en = ($urandom_range(0, 3) != 0);
      s_sync_in = ($urandom_range(0, 7) == 0);
      s_ring_src = 1'($urandom_range(0, 1));
      for (int v = 0; v < 2; v++) begin
        if ($urandom_range(0, 15) == 0) begin
          s_freq[v]    = $urandom_range(0, 32'hFFFF);
          s_pw[v]      = $urandom_range(0, 32'hFFF);
          s_ws[v]      = 4'($urandom_range(0, 15));
          s_en_sync[v] = 1'($urandom_range(0, 1));
          s_en_ring[v] = 1'($urandom_range(0, 1));
        end
        s_test[v] = ($urandom_range(0, 49) == 0);
      end
      cycle($urandom_range(0, 399) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
